// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_pkg
//  Description : Shared types and constants for the 1011 serial detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

    // Matched-prefix states of the detector
    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    // Pattern being detected, oldest bit in the MSB
    localparam logic [3:0] PATTERN = 4'b1011;

endpackage
`default_nettype wire

// File: rtl/seq_detect.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect
//  Description : Moore FSM that pulses dout for one cycle on every 1011 seen
//                on the serial input in_d. OVERLAP selects whether a match's
//                suffix may seed the next match.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect
    import seq_detect_pkg::*;
#(
    parameter logic OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_d,
    output logic dout
);

    // Explicit-width state encodings, taken from the shared enum so the
    // package stays the single source of truth for the encoding.
    localparam logic [2:0] c_st_s0    = S0;
    localparam logic [2:0] c_st_s1    = S1;
    localparam logic [2:0] c_st_s10   = S10;
    localparam logic [2:0] c_st_s101  = S101;
    localparam logic [2:0] c_st_s1011 = S1011;

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    // State register; reset wins over any transition and ignores in_d
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_s0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; unused encodings fall back to S0
    always_comb begin
        w_next_state = c_st_s0;
        case (r_state)
            c_st_s0:    w_next_state = in_d ? c_st_s1    : c_st_s0;
            c_st_s1:    w_next_state = in_d ? c_st_s1    : c_st_s10;
            c_st_s10:   w_next_state = in_d ? c_st_s101  : c_st_s0;
            c_st_s101:  w_next_state = in_d ? c_st_s1011 : c_st_s10;
            c_st_s1011: begin
                // With overlap, the trailing "1" of 1011 is a valid prefix;
                // without it, the current bit is judged as a first bit.
                if (OVERLAP) begin
                    w_next_state = in_d ? c_st_s1 : c_st_s10;
                end else begin
                    w_next_state = in_d ? c_st_s1 : c_st_s0;
                end
            end
            default:    w_next_state = c_st_s0;
        endcase
    end

    // Moore output: pure decode of the registered state
    assign dout = (r_state == c_st_s1011);

endmodule
`default_nettype wire

// File: tb/tb_seq_detect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect
//  Description : Self-checking bench for seq_detect, exercising both the
//                overlapping and non-overlapping variants side by side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect;
    import seq_detect_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic in_d;
    logic dout_ov;
    logic dout_nov;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic rst;
        logic in_d;
        logic exp_ov;
        logic exp_nov;
    } vec_t;

    vec_t vecs[$];

    // Reference model history: bits since reset (overlap) or since reset /
    // last match (non-overlap), trimmed to the newest four.
    logic q_ov[$];
    logic q_nov[$];

    seq_detect #(.OVERLAP(1'b1)) dut_ov (
        .clk  (clk),
        .rst  (rst),
        .in_d (in_d),
        .dout (dout_ov)
    );

    seq_detect #(.OVERLAP(1'b0)) dut_nov (
        .clk  (clk),
        .rst  (rst),
        .in_d (in_d),
        .dout (dout_nov)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: dout=%0b expected %0b", name, act, exp);
        end
    endtask

    // Drive one bit away from the active edge, then sample just after it
    task automatic step(input logic r, input logic b);
        @(negedge clk);
        rst  = r;
        in_d = b;
        @(posedge clk);
        #1;
    endtask

    // Queue a reset row followed by an n-bit stream (MSB first)
    task automatic add_seq(input int n, input logic [7:0] bits,
                           input logic [7:0] eov, input logic [7:0] enov);
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < n; i++) begin
            vecs.push_back('{1'b0, bits[n-1-i], eov[n-1-i], enov[n-1-i]});
        end
    endtask

    function automatic logic tail_matches(input logic q[$]);
        logic [3:0] w;
        if (q.size() < 4) return 1'b0;
        w = {q[q.size()-4], q[q.size()-3], q[q.size()-2], q[q.size()-1]};
        return w == PATTERN;
    endfunction

    task automatic model_step(input logic r, input logic b,
                              output logic e_ov, output logic e_nov);
        if (r) begin
            q_ov.delete();
            q_nov.delete();
            e_ov  = 1'b0;
            e_nov = 1'b0;
        end else begin
            q_ov.push_back(b);
            q_nov.push_back(b);
            if (q_ov.size() > 4) void'(q_ov.pop_front());
            if (q_nov.size() > 4) void'(q_nov.pop_front());
            e_ov  = tail_matches(q_ov);
            e_nov = tail_matches(q_nov);
            // A non-overlapping match consumes every bit seen so far
            if (e_nov) q_nov.delete();
        end
    endtask

    initial begin
        logic e_ov;
        logic e_nov;
        logic r;
        logic b;

        rst  = 1'b1;
        in_d = 1'b0;

        // Reset held with toggling data, then directed streams
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
        add_seq(5, 8'b10110,    8'b00010,    8'b00010);
        add_seq(7, 8'b1011011,  8'b0001001,  8'b0001000);
        add_seq(8, 8'b10111011, 8'b00010001, 8'b00010001);
        add_seq(6, 8'b101011,   8'b000001,   8'b000001);
        add_seq(4, 8'b1111,     8'b0000,     8'b0000);
        add_seq(4, 8'b0000,     8'b0000,     8'b0000);
        add_seq(5, 8'b10011,    8'b00000,    8'b00000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].in_d);
            check($sformatf("tbl_ov[%0d]", i),  dout_ov,  vecs[i].exp_ov);
            check($sformatf("tbl_nov[%0d]", i), dout_nov, vecs[i].exp_nov);
        end

        // Reset mid-sequence discards the 101 prefix
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("midrst_pre_ov", dout_ov, 1'b0);
        step(1'b1, 1'b1);
        check("midrst_rst_ov",  dout_ov,  1'b0);
        check("midrst_rst_nov", dout_nov, 1'b0);
        step(1'b0, 1'b1);
        check("midrst_b1_ov", dout_ov, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("midrst_b3_ov", dout_ov, 1'b0);
        step(1'b0, 1'b1);
        check("midrst_hit_ov",  dout_ov,  1'b1);
        check("midrst_hit_nov", dout_nov, 1'b1);
        step(1'b0, 1'b0);
        check("midrst_fall_ov", dout_ov, 1'b0);

        // Randomized stream against the history-based model
        step(1'b1, 1'b0);
        model_step(1'b1, 1'b0, e_ov, e_nov);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 39) == 0);
            b = 1'($urandom_range(0, 1));
            step(r, b);
            model_step(r, b, e_ov, e_nov);
            check($sformatf("rnd_ov[%0d]", i),  dout_ov,  e_ov);
            check($sformatf("rnd_nov[%0d]", i), dout_nov, e_nov);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
